// File: rtl/washing_machine_plant_model.sv
// Plant/sensor emulator for the washing machine controller: water level, detergent
// dispenser and wash/spin timers driven by the controller's actuator commands.
module washing_machine_plant_model #(
  parameter int LEVEL_W     = 8,
  parameter int FULL_LEVEL  = 200,
  parameter int MAX_LEVEL   = 250,
  parameter int FILL_RATE   = 4,
  parameter int DRAIN_RATE  = 8,
  parameter int DET_DELAY   = 16,
  parameter int WASH_CYCLES = 1000,
  parameter int SPIN_CYCLES = 500,
  parameter int TIMER_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               door_lock,
  input  logic               motor_on,
  input  logic               fill_valve_on,
  input  logic               drain_valve_on,
  input  logic               done,
  output logic               filled,
  output logic               drained,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] water_level,
  output logic               fault
);

  localparam int LW2 = LEVEL_W + 2;
  localparam logic signed [LW2-1:0] FILL_S  = LW2'(FILL_RATE);
  localparam logic signed [LW2-1:0] DRAIN_S = LW2'(DRAIN_RATE);
  localparam logic signed [LW2-1:0] MAX_S   = LW2'(MAX_LEVEL);
  localparam logic signed [LW2-1:0] ZERO_S  = '0;

  typedef enum logic [2:0] {IDLE, WASH, WASHED, SPIN, SPUN} phase_t;

  phase_t               state_q, state_d;
  logic [TIMER_W-1:0]   tmr_q, tmr_d, det_q, det_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 det_add_q, det_add_d;
  logic                 cto_q, cto_d, sto_q, sto_d;
  logic                 fault_q, fault_d;
  logic signed [LW2-1:0] lvl_sum;
  logic                 clear;

  assign water_level     = level_q;
  assign filled          = (level_q >= LEVEL_W'(FULL_LEVEL));
  assign drained         = (level_q == '0);
  assign detergent_added = det_add_q;
  assign cycle_timeout   = cto_q;
  assign spin_timeout    = sto_q;
  assign fault           = fault_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      det_q     <= '0;
      level_q   <= '0;
      det_add_q <= 1'b0;
      cto_q     <= 1'b0;
      sto_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      det_q     <= det_d;
      level_q   <= level_d;
      det_add_q <= det_add_d;
      cto_q     <= cto_d;
      sto_q     <= sto_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    det_d     = det_q;
    det_add_d = det_add_q;
    cto_d     = cto_q;
    sto_d     = sto_q;
    clear     = 1'b0;

    // Signed headroom so a drain below zero or a fill past MAX can be clamped.
    lvl_sum = $signed({2'b00, level_q})
            + (fill_valve_on  ? FILL_S  : ZERO_S)
            - (drain_valve_on ? DRAIN_S : ZERO_S);
    if (lvl_sum < ZERO_S)      level_d = '0;
    else if (lvl_sum > MAX_S)  level_d = LEVEL_W'(MAX_LEVEL);
    else                       level_d = lvl_sum[LEVEL_W-1:0];

    fault_d = fault_q | (fill_valve_on & ~door_lock) | (lvl_sum >= MAX_S);

    // Dispenser timer pauses (keeps its count) whenever the tub is not full.
    if (door_lock && filled && !det_add_q) begin
      det_d = det_q + 1'b1;
      if (det_q == TIMER_W'(DET_DELAY - 1)) det_add_d = 1'b1;
    end

    if (state_q != IDLE && !door_lock) begin
      state_d = IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (door_lock && motor_on && !drain_valve_on && filled && det_add_q) begin
          state_d = WASH;
          tmr_d   = '0;
        end
        WASH: if (motor_on) begin
          tmr_d = tmr_q + 1'b1;
          if (tmr_q == TIMER_W'(WASH_CYCLES - 1)) begin
            cto_d   = 1'b1;
            state_d = WASHED;
          end
        end
        WASHED: if (motor_on && drain_valve_on && drained) begin
          state_d = SPIN;
          tmr_d   = '0;
        end
        SPIN: if (motor_on) begin
          tmr_d = tmr_q + 1'b1;
          if (tmr_q == TIMER_W'(SPIN_CYCLES - 1)) begin
            sto_d   = 1'b1;
            state_d = SPUN;
          end
        end
        SPUN: if (done) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (clear) begin
      tmr_d     = '0;
      det_d     = '0;
      det_add_d = 1'b0;
      cto_d     = 1'b0;
      sto_d     = 1'b0;
    end
  end

endmodule

// File: tb/tb_washing_machine_plant_model.sv
// Directed closed-loop bench for washing_machine_plant_model with a cycle-level
// reference model and hand-computed checkpoints.
module tb_washing_machine_plant_model;
  localparam int LEVEL_W = 8, FULL = 20, MAXL = 32, FILL = 4, DRAIN = 5;
  localparam int DET = 3, WASHN = 10, SPINN = 6, TIMER_W = 16;
  localparam int P_IDLE = 0, P_WASH = 1, P_WASHED = 2, P_SPIN = 3, P_SPUN = 4;

  logic clk = 1'b0;
  logic rst, door_lock, motor_on, fill_valve_on, drain_valve_on, done;
  logic filled, drained, detergent_added, cycle_timeout, spin_timeout, fault;
  logic [LEVEL_W-1:0] water_level;

  int n_chk = 0, n_fail = 0;

  washing_machine_plant_model #(
    .LEVEL_W(LEVEL_W), .FULL_LEVEL(FULL), .MAX_LEVEL(MAXL), .FILL_RATE(FILL),
    .DRAIN_RATE(DRAIN), .DET_DELAY(DET), .WASH_CYCLES(WASHN),
    .SPIN_CYCLES(SPINN), .TIMER_W(TIMER_W)
  ) dut (
    .clk(clk), .rst(rst), .door_lock(door_lock), .motor_on(motor_on),
    .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on), .done(done),
    .filled(filled), .drained(drained), .detergent_added(detergent_added),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
    .water_level(water_level), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level as a clamped integer, phase timers as countdowns.
  int m_level, m_det_cnt, m_left, m_phase, raw;
  bit m_det, m_cto, m_sto, m_fault, was_full, was_empty;

  function automatic void wipe();
    m_phase = P_IDLE; m_left = 0; m_det_cnt = 0;
    m_det = 0; m_cto = 0; m_sto = 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wipe();
      m_level = 0; m_fault = 0;
    end else begin
      was_full  = (m_level >= FULL);
      was_empty = (m_level == 0);
      raw = m_level + (fill_valve_on ? FILL : 0) - (drain_valve_on ? DRAIN : 0);
      if ((fill_valve_on && !door_lock) || raw >= MAXL) m_fault = 1;
      m_level = (raw < 0) ? 0 : ((raw > MAXL) ? MAXL : raw);
      if (door_lock && was_full && !m_det) begin
        m_det_cnt++;
        m_det = (m_det_cnt == DET);
      end
      if (m_phase != P_IDLE && !door_lock) wipe();
      else case (m_phase)
        P_IDLE: if (door_lock && motor_on && !drain_valve_on && was_full && m_det) begin
          m_phase = P_WASH; m_left = WASHN;
        end
        P_WASH: if (motor_on) begin
          m_left--;
          if (m_left == 0) begin m_cto = 1; m_phase = P_WASHED; end
        end
        P_WASHED: if (motor_on && drain_valve_on && was_empty) begin
          m_phase = P_SPIN; m_left = SPINN;
        end
        P_SPIN: if (motor_on) begin
          m_left--;
          if (m_left == 0) begin m_sto = 1; m_phase = P_SPUN; end
        end
        P_SPUN: if (done) wipe();
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    check("model water_level", int'(water_level), m_level);
    check("model filled", int'(filled), int'(m_level >= FULL));
    check("model drained", int'(drained), int'(m_level == 0));
    check("model detergent_added", int'(detergent_added), int'(m_det));
    check("model cycle_timeout", int'(cycle_timeout), int'(m_cto));
    check("model spin_timeout", int'(spin_timeout), int'(m_sto));
    check("model fault", int'(fault), int'(m_fault));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; door_lock = 0; motor_on = 0; fill_valve_on = 0;
    drain_valve_on = 0; done = 0;
    #1 rst = 1'b0;
    step(2);
    check("reset level", int'(water_level), 0);
    check("reset drained", int'(drained), 1);
    check("reset filled", int'(filled), 0);
    check("reset flags", int'({detergent_added, cycle_timeout, spin_timeout, fault}), 0);
    rst = 1'b1;

    // Fill to FULL and dispense detergent
    door_lock = 1; fill_valve_on = 1;
    step(1); check("fill edge1 drained", int'(drained), 0);
             check("fill edge1 level", int'(water_level), 4);
    step(4); check("fill edge5 level", int'(water_level), 20);
             check("fill edge5 filled", int'(filled), 1);
    fill_valve_on = 0;
    step(2); check("det before 3 edges", int'(detergent_added), 0);
    step(1); check("det at 3 edges", int'(detergent_added), 1);

    // Uninterrupted wash
    motor_on = 1;
    step(1);
    step(9);  check("wash 9 edges", int'(cycle_timeout), 0);
    step(1);  check("wash 10 edges", int'(cycle_timeout), 1);

    // Drain and spin, then done
    drain_valve_on = 1;
    step(4);  check("drain 4 edges", int'(drained), 1);
              check("drain level", int'(water_level), 0);
    step(6);  check("spin early", int'(spin_timeout), 0);
    step(1);  check("spin timeout", int'(spin_timeout), 1);
    motor_on = 0; drain_valve_on = 0; done = 1;
    step(1);  done = 0;
    check("done clears flags", int'({detergent_added, cycle_timeout, spin_timeout}), 0);

    // Wash with a 4-cycle motor pause
    fill_valve_on = 1; step(5); fill_valve_on = 0;
    step(3);  check("refill det", int'(detergent_added), 1);
    motor_on = 1; step(1);
    step(5);  motor_on = 0;
    step(4);  motor_on = 1;
    step(4);  check("paused wash edge13", int'(cycle_timeout), 0);
    step(1);  check("paused wash edge14", int'(cycle_timeout), 1);

    // Abort from WASHED, then abort mid-WASH at timer 5
    door_lock = 0; motor_on = 0;
    step(1);  check("abort washed cto", int'(cycle_timeout), 0);
    door_lock = 1;
    step(3);  check("det after abort", int'(detergent_added), 1);
    motor_on = 1; step(1); step(5);
    door_lock = 0;
    step(1);  check("abort wash cto", int'(cycle_timeout), 0);
              check("abort wash det", int'(detergent_added), 0);
              check("abort wash level", int'(water_level), 20);

    // Reach SPIN, then asynchronous reset between edges
    door_lock = 1; motor_on = 0;
    step(3); motor_on = 1;
    step(11); check("second wash cto", int'(cycle_timeout), 1);
    drain_valve_on = 1;
    step(7);  check("mid spin sto", int'(spin_timeout), 0);
    #2 rst = 1'b0;
    #1;
    check("async rst level", int'(water_level), 0);
    check("async rst drained", int'(drained), 1);
    check("async rst cto", int'(cycle_timeout), 0);
    check("async rst det", int'(detergent_added), 0);
    @(negedge clk);
    rst = 1'b1; motor_on = 0; drain_valve_on = 0;

    // Both valves, then overflow
    fill_valve_on = 1; step(5);
    fill_valve_on = 0; drain_valve_on = 1;
    step(2);  check("drain to 10", int'(water_level), 10);
    fill_valve_on = 1;
    step(1);  check("both valves 9", int'(water_level), 9);
    step(1);  check("both valves 8", int'(water_level), 8);
    step(4);  check("both valves 4", int'(water_level), 4);
    drain_valve_on = 0;
    step(6);  check("fill to 28", int'(water_level), 28);
              check("no fault at 28", int'(fault), 0);
    step(1);  check("clamp 32", int'(water_level), 32);
              check("overflow fault", int'(fault), 1);
    step(1);  check("held 32", int'(water_level), 32);
    fill_valve_on = 0; drain_valve_on = 1;
    step(1);  check("drain from max", int'(water_level), 27);
              check("fault sticky", int'(fault), 1);

    // Fill with door unlocked after a fresh reset
    drain_valve_on = 0; door_lock = 0;
    rst = 1'b0; step(1);
    check("fresh reset fault", int'(fault), 0);
    rst = 1'b1; fill_valve_on = 1;
    step(1);  check("unlocked fill fault", int'(fault), 1);
              check("unlocked fill level", int'(water_level), 4);
    fill_valve_on = 0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
